// File: rtl/mmio_timer_slave_pkg.sv
// Shared definitions for the memory-mapped timer and its data-port lane logic.
// Register offsets, bit positions and access-width codes are reused by DMEM.
package timer_pkg;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_LOAD   = 5'h04;
    localparam logic [4:0] REG_COUNT  = 5'h08;
    localparam logic [4:0] REG_STATUS = 5'h0C;
    localparam logic [4:0] REG_PRESC  = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_AUTO   = 2;
    localparam int STAT_EXP    = 0;
    localparam int STAT_ALNERR = 1;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} timer_state_e;

    // Replace only the byte lanes selected by mask.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_slave_if.sv
// CPU data-port bundle shared with DMEM: the CPU drives ena/WR/w/addr/datain_*,
// the responder returns read data combinationally in the same cycle, no wait states.
interface mmio_timer_slave_if;
    logic        ena;
    logic        WR;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] datain_32;
    logic [15:0] datain_16;
    logic [7:0]  datain_8;
    logic [31:0] dataout_32;
    logic [15:0] dataout_16;
    logic [7:0]  dataout_8;
    logic        sel;

    modport master (
        output ena, WR, w, addr, datain_32, datain_16, datain_8,
        input  dataout_32, dataout_16, dataout_8, sel
    );

    modport slave (
        input  ena, WR, w, addr, datain_32, datain_16, datain_8,
        output dataout_32, dataout_16, dataout_8, sel
    );
endinterface

// File: rtl/mmio_timer_slave_bus_lane_ctl.sv
// Turns access width and low address bits into a byte-write mask, lane-replicated
// write data and a misalignment flag.
module bus_lane_ctl
    import timer_pkg::*;
(
    input  logic [1:0]  i_w,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_datain_32,
    input  logic [15:0] i_datain_16,
    input  logic [7:0]  i_datain_8,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_mask       = 4'b1111;
        o_wdata      = i_datain_32;
        o_misaligned = 1'b0;
        case (i_w)
            W_BYTE: begin
                o_mask  = 4'b0001 << i_off;
                o_wdata = {4{i_datain_8}};
            end
            W_HALF: begin
                o_mask       = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_datain_16}};
                o_misaligned = i_off[0];
            end
            default: begin
                o_misaligned = (i_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Down-counting timer with prescaler and level interrupt, answering the CPU
// data port in a 0x14-byte window at BASE_ADDR.
module mmio_timer_slave
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h10020000,
    parameter int          PRE_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    mmio_timer_slave_if.slave   bus,
    output logic                irq,
    output timer_state_e        o_dbg_state
);

    timer_state_e     r_state, w_state_nxt;
    logic             r_ie, r_auto, r_exp, r_alnerr;
    logic [31:0]      r_load, r_count, w_count_nxt;
    logic [PRE_W-1:0] r_presc, r_precnt, w_precnt_nxt;

    logic [31:0] w_off, w_rd_val, w_wr_new, w_wdata;
    logic [31:0] w_ctrl_rd, w_status_rd, w_presc_rd;
    logic [4:0]  w_idx_off;
    logic [3:0]  w_mask;
    logic        w_sel, w_mis, w_wr, w_rd_ok, w_tick, w_expire;
    logic        w_wr_ctrl, w_wr_load, w_wr_status, w_wr_presc, w_clr_exp, w_clr_aln;

    assign w_off     = bus.addr - BASE_ADDR;
    assign w_sel     = bus.ena && (bus.addr >= BASE_ADDR) && (w_off < 32'd20);
    assign w_idx_off = {w_off[4:2], 2'b00};

    bus_lane_ctl u_lane (
        .i_w          (bus.w),
        .i_off        (w_off[1:0]),
        .i_datain_32  (bus.datain_32),
        .i_datain_16  (bus.datain_16),
        .i_datain_8   (bus.datain_8),
        .o_mask       (w_mask),
        .o_wdata      (w_wdata),
        .o_misaligned (w_mis)
    );

    assign w_wr    = w_sel && bus.WR && !w_mis;
    assign w_rd_ok = w_sel && !bus.WR && !w_mis;

    always_comb begin
        w_ctrl_rd              = '0;
        w_ctrl_rd[CTRL_EN]     = (r_state == S_RUN);
        w_ctrl_rd[CTRL_IE]     = r_ie;
        w_ctrl_rd[CTRL_AUTO]   = r_auto;
        w_status_rd              = '0;
        w_status_rd[STAT_EXP]    = r_exp;
        w_status_rd[STAT_ALNERR] = r_alnerr;
        w_presc_rd             = '0;
        w_presc_rd[PRE_W-1:0]  = r_presc;
        w_rd_val               = '0;
        case (w_idx_off)
            REG_CTRL:   w_rd_val = w_ctrl_rd;
            REG_LOAD:   w_rd_val = r_load;
            REG_COUNT:  w_rd_val = r_count;
            REG_STATUS: w_rd_val = w_status_rd;
            REG_PRESC:  w_rd_val = w_presc_rd;
            default:    w_rd_val = '0;
        endcase
    end

    // The addressed register's current value doubles as the merge base for partial writes.
    assign w_wr_new    = merge_lanes(w_rd_val, w_wdata, w_mask);
    assign w_wr_ctrl   = w_wr && (w_idx_off == REG_CTRL);
    assign w_wr_load   = w_wr && (w_idx_off == REG_LOAD);
    assign w_wr_status = w_wr && (w_idx_off == REG_STATUS);
    assign w_wr_presc  = w_wr && (w_idx_off == REG_PRESC);
    assign w_clr_exp   = w_wr_status && w_mask[0] && w_wdata[STAT_EXP];
    assign w_clr_aln   = w_wr_status && w_mask[0] && w_wdata[STAT_ALNERR];

    assign bus.sel        = w_sel;
    assign bus.dataout_32 = w_rd_ok ? w_rd_val : '0;
    assign bus.dataout_16 = w_rd_ok ? (w_off[1] ? w_rd_val[31:16] : w_rd_val[15:0]) : '0;
    assign bus.dataout_8  = w_rd_ok ? w_rd_val[{w_off[1:0], 3'b000} +: 8] : '0;

    // Any CTRL write suspends counting for that cycle; a 0->1 EN edge restarts from LOAD.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_precnt_nxt = r_precnt;
        w_tick       = 1'b0;
        w_expire     = 1'b0;
        if (w_wr_ctrl) begin
            w_state_nxt = w_wr_new[CTRL_EN] ? S_RUN : S_IDLE;
            if (r_state == S_IDLE && w_wr_new[CTRL_EN]) begin
                w_count_nxt  = r_load;
                w_precnt_nxt = '0;
            end
        end else if (r_state == S_RUN) begin
            if (r_precnt == r_presc) begin
                w_precnt_nxt = '0;
                w_tick       = 1'b1;
            end else begin
                w_precnt_nxt = r_precnt + 1'b1;
            end
            if (w_tick) begin
                if (r_count != 32'd0) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    w_expire = 1'b1;
                    if (r_auto) w_count_nxt = r_load;
                    else        w_state_nxt = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ie     <= 1'b0;
            r_auto   <= 1'b0;
            r_load   <= '0;
            r_count  <= '0;
            r_exp    <= 1'b0;
            r_alnerr <= 1'b0;
            r_presc  <= '0;
            r_precnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_precnt <= w_precnt_nxt;
            if (w_wr_ctrl) begin
                r_ie   <= w_wr_new[CTRL_IE];
                r_auto <= w_wr_new[CTRL_AUTO];
            end
            if (w_wr_load)  r_load  <= w_wr_new;
            if (w_wr_presc) r_presc <= w_wr_new[PRE_W-1:0];
            if (w_expire)       r_exp <= 1'b1;
            else if (w_clr_exp) r_exp <= 1'b0;
            if (w_sel && w_mis) r_alnerr <= 1'b1;
            else if (w_clr_aln) r_alnerr <= 1'b0;
        end
    end

    assign irq         = r_exp && r_ie;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Bench for mmio_timer_slave: directed scenarios with literal expectations, then
// random bus traffic, all checked every cycle against a register-level model.
module tb_mmio_timer_slave;
    import timer_pkg::*;

    localparam logic [31:0] BASE = 32'h10020000;

    logic         clk;
    logic         rst;
    logic         irq;
    timer_state_e dbg_state;

    mmio_timer_slave_if bus();

    mmio_timer_slave #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .irq         (irq),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    bit          m_en, m_ie, m_auto, m_exp, m_aln;
    logic [31:0] m_load, m_count;
    logic [15:0] m_presc, m_precnt;

    logic [31:0] last_d32;
    logic [15:0] last_d16;
    logic [7:0]  last_d8;
    logic        last_sel, last_irq;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(int idx);
        case (idx)
            0: return {29'b0, m_auto, m_ie, m_en};
            1: return m_load;
            2: return m_count;
            3: return {30'b0, m_aln, m_exp};
            4: return {16'b0, m_presc};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int acc_size(logic [1:0] ww);
        return (ww == W_HALF) ? 2 : (ww == W_BYTE) ? 1 : 4;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd20);
    endfunction

    task automatic model_step();
        logic [31:0] off, data, nv;
        int          size, idx, lane0;
        bit          acc, mis, ctrl_wr, new_en, tick, expire, clr_exp, clr_aln;
        bit          load_wr, presc_wr;
        if (rst) begin
            m_en = 0; m_ie = 0; m_auto = 0; m_exp = 0; m_aln = 0;
            m_load = 0; m_count = 0; m_presc = 0; m_precnt = 0;
            return;
        end
        acc  = bus.ena && in_window(bus.addr);
        off  = bus.addr - BASE;
        idx  = int'(off[4:2]);
        size = acc_size(bus.w);
        mis  = (off % size) != 0;
        lane0 = int'(off[1:0]);
        ctrl_wr = 0; new_en = 0; tick = 0; expire = 0; clr_exp = 0; clr_aln = 0;
        load_wr = 0; presc_wr = 0; nv = 0;
        if (acc && !mis && bus.WR) begin
            data = (size == 4) ? bus.datain_32 : (size == 2) ? {16'b0, bus.datain_16} : {24'b0, bus.datain_8};
            nv = m_reg(idx);
            for (int j = 0; j < size; j++) nv[8*(lane0+j) +: 8] = data[8*j +: 8];
            case (idx)
                0: begin ctrl_wr = 1; new_en = nv[0]; end
                1: load_wr = 1;
                3: begin clr_exp = (lane0 == 0) && data[0]; clr_aln = (lane0 == 0) && data[1]; end
                4: presc_wr = 1;
                default: ;
            endcase
        end
        // Counter advances on old register values; register writes land afterwards.
        if (ctrl_wr) begin
            if (!m_en && new_en) begin
                m_count  = m_load;
                m_precnt = 0;
            end
            m_en = new_en;
        end else if (m_en) begin
            if (m_precnt == m_presc) begin
                m_precnt = 0;
                tick = 1;
            end else begin
                m_precnt = m_precnt + 16'd1;
            end
            if (tick) begin
                if (m_count != 0) m_count = m_count - 1;
                else begin
                    expire = 1;
                    if (m_auto) m_count = m_load;
                    else        m_en = 0;
                end
            end
        end
        if (ctrl_wr) begin m_ie = nv[1]; m_auto = nv[2]; end
        if (load_wr)  m_load  = nv;
        if (presc_wr) m_presc = nv[15:0];
        if (expire)       m_exp = 1;
        else if (clr_exp) m_exp = 0;
        if (acc && mis)   m_aln = 1;
        else if (clr_aln) m_aln = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] off, val, e32;
        logic [15:0] e16;
        logic [7:0]  e8;
        bit          acc, ok;
        acc = bus.ena && in_window(bus.addr);
        off = bus.addr - BASE;
        ok  = acc && !bus.WR && ((off % acc_size(bus.w)) == 0);
        val = m_reg(int'(off[4:2]));
        e32 = ok ? val : 32'h0;
        e16 = ok ? (off[1] ? val[31:16] : val[15:0]) : 16'h0;
        e8  = ok ? 8'(val >> (8 * off[1:0])) : 8'h0;
        last_d32 = bus.dataout_32;
        last_d16 = bus.dataout_16;
        last_d8  = bus.dataout_8;
        last_sel = bus.sel;
        last_irq = irq;
        chk("sel",        32'(bus.sel),        32'(acc));
        chk("dataout_32", bus.dataout_32,      e32);
        chk("dataout_16", 32'(bus.dataout_16), 32'(e16));
        chk("dataout_8",  32'(bus.dataout_8),  32'(e8));
        chk("irq",        32'(irq),            32'(m_exp && m_ie));
        chk("dbg_state",  32'(dbg_state),      32'(m_en));
    endtask

    task automatic drive(bit e, bit wr_b, logic [1:0] ww, logic [31:0] a, logic [31:0] d);
        bus.ena = e; bus.WR = wr_b; bus.w = ww; bus.addr = a;
        bus.datain_32 = d; bus.datain_16 = d[15:0]; bus.datain_8 = d[7:0];
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(logic [1:0] ww, logic [31:0] a, logic [31:0] d);
        drive(1, 1, ww, a, d);
        cycle();
    endtask

    task automatic rd(logic [1:0] ww, logic [31:0] a);
        drive(1, 0, ww, a, 32'h0);
        cycle();
    endtask

    task automatic idle();
        drive(0, 0, W_WORD, 32'h0, 32'h0);
        cycle();
    endtask

    initial begin
        logic [31:0] a, d, off;
        logic [1:0]  ww;
        logic [31:0] exp_cnt[7];

        rst = 1'b1;
        drive(0, 0, W_WORD, 32'h0, 32'h0);
        @(negedge clk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0;

        // Reset values and decode window
        for (int i = 0; i < 5; i++) begin
            rd(W_WORD, BASE + 32'(4*i));
            chk("reset_reg", last_d32, 32'h0);
            chk("reset_irq", 32'(last_irq), 32'h0);
        end
        rd(W_WORD, BASE + 32'h14);
        chk("beyond_window_sel", 32'(last_sel), 32'h0);
        chk("beyond_window_data", last_d32, 32'h0);
        rd(W_WORD, 32'h10010000);
        chk("dmem_addr_sel", 32'(last_sel), 32'h0);

        // One-shot, prescaler 0
        wr(W_WORD, BASE + 32'h04, 32'd3);
        wr(W_WORD, BASE + 32'h10, 32'd0);
        wr(W_WORD, BASE + 32'h00, 32'h3);
        for (int i = 0; i < 4; i++) begin
            rd(W_WORD, BASE + 32'h08);
            chk("oneshot_count", last_d32, 32'(3 - i));
        end
        rd(W_WORD, BASE + 32'h0C);
        chk("oneshot_status", last_d32, 32'h1);
        chk("oneshot_irq", 32'(last_irq), 32'h1);
        rd(W_WORD, BASE + 32'h00);
        chk("oneshot_ctrl", last_d32, 32'h2);

        // Auto-reload, prescaler 1
        wr(W_WORD, BASE + 32'h0C, 32'h3);
        wr(W_WORD, BASE + 32'h04, 32'd2);
        wr(W_WORD, BASE + 32'h10, 32'd1);
        wr(W_WORD, BASE + 32'h00, 32'h7);
        exp_cnt = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};
        for (int i = 0; i < 7; i++) begin
            rd(W_WORD, BASE + 32'h08);
            chk("auto_count", last_d32, exp_cnt[i]);
        end
        chk("auto_irq", 32'(last_irq), 32'h1);
        rd(W_WORD, BASE + 32'h00);
        chk("auto_ctrl", last_d32, 32'h7);
        wr(W_WORD, BASE + 32'h0C, 32'h1);
        rd(W_WORD, BASE + 32'h0C);
        chk("auto_w1c_status", last_d32, 32'h0);
        chk("auto_w1c_irq", 32'(last_irq), 32'h0);
        wr(W_WORD, BASE + 32'h00, 32'h0);

        // Lane writes and reads
        wr(W_WORD, BASE + 32'h04, 32'h0);
        wr(W_BYTE, BASE + 32'h05, 32'hAB);
        wr(W_HALF, BASE + 32'h06, 32'h1234);
        rd(W_WORD, BASE + 32'h04);
        chk("lane_load", last_d32, 32'h1234AB00);
        rd(W_BYTE, BASE + 32'h06);
        chk("lane_byte_rd", 32'(last_d8), 32'h34);

        // Misaligned accesses
        wr(W_HALF, BASE + 32'h05, 32'hFFFF);
        rd(W_WORD, BASE + 32'h04);
        chk("misaligned_wr_dropped", last_d32, 32'h1234AB00);
        rd(W_WORD, BASE + 32'h0A);
        chk("misaligned_rd_32", last_d32, 32'h0);
        chk("misaligned_rd_16", 32'(last_d16), 32'h0);
        rd(W_WORD, BASE + 32'h0C);
        chk("alnerr_set", last_d32, 32'h2);
        wr(W_WORD, BASE + 32'h0C, 32'h2);
        rd(W_WORD, BASE + 32'h0C);
        chk("alnerr_clr", last_d32, 32'h0);

        // W1C colliding with expiry
        wr(W_WORD, BASE + 32'h04, 32'd1);
        wr(W_WORD, BASE + 32'h10, 32'd0);
        wr(W_WORD, BASE + 32'h00, 32'h3);
        idle();
        wr(W_WORD, BASE + 32'h0C, 32'h1);
        rd(W_WORD, BASE + 32'h0C);
        chk("w1c_vs_expiry", last_d32, 32'h1);
        rd(W_WORD, BASE + 32'h00);
        chk("w1c_vs_expiry_ctrl", last_d32, 32'h2);

        // Reset mid-count
        wr(W_WORD, BASE + 32'h0C, 32'h1);
        wr(W_WORD, BASE + 32'h04, 32'd2);
        wr(W_WORD, BASE + 32'h00, 32'h7);
        idle(); idle(); idle();
        rd(W_WORD, BASE + 32'h08);
        chk("pre_reset_irq", 32'(last_irq), 32'h1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        rd(W_WORD, BASE + 32'h08);
        chk("post_reset_count", last_d32, 32'h0);
        chk("post_reset_irq", 32'(last_irq), 32'h0);
        rd(W_WORD, BASE + 32'h00);
        chk("post_reset_ctrl", last_d32, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ww  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 23));
            off = a - BASE;
            d   = $urandom;
            // Keep LOAD/PRESC small so expiries happen often.
            if (in_window(a) && (off[4:2] == 3'd1 || off[4:2] == 3'd4))
                d = (off[1:0] == 2'b00) ? 32'($urandom_range(0, 5)) : 32'h0;
            drive($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), ww, a, d);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
